// File: rtl/data_memory_pipe.sv
// rtl/data_memory_pipe.sv - word-organised data memory serving LSU loads/stores over valid/ready channels
// Byte-lane steering on stores, lane select plus extension on loads, misalign/range errors reported.
package data_memory_pipe_pkg;
  typedef enum logic [1:0] {
    MEM_SIZE_B = 2'd0,
    MEM_SIZE_H = 2'd1,
    MEM_SIZE_W = 2'd2
  } mem_size_t;
endpackage

module data_memory_pipe
  import data_memory_pipe_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 1,
  parameter int CHECK_ALIGN = 1,
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  mem_size_t             req_size,
  input  logic                  req_sign,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_err
);
  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam int CNT_W = 4;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t                  state, state_nxt;
  logic [CNT_W-1:0]        cnt, cnt_nxt;
  logic [DATA_WIDTH-1:0]   mem [DEPTH_WORDS];

  logic [IDX_W-1:0]        idx;
  logic [1:0]              lane, lane_eff;
  mem_size_t               size_eff;
  logic                    out_of_range, misaligned, err, accept, wr_en;
  logic [3:0]              be;
  logic [DATA_WIDTH-1:0]   wdata_rep, rd_word, rd_shift, rdata_fmt;

  assign idx          = req_addr[IDX_W+1:2];
  assign lane         = req_addr[1:0];
  assign out_of_range = |(req_addr >> (IDX_W + 2));

  // H/W lanes are forced aligned; when alignment is checked, err masks any effect anyway
  always_comb begin
    size_eff   = MEM_SIZE_W;
    lane_eff   = 2'b00;
    be         = 4'hF;
    wdata_rep  = req_wdata;
    misaligned = 1'b0;
    case (req_size)
      MEM_SIZE_B: begin
        size_eff  = MEM_SIZE_B;
        lane_eff  = lane;
        be        = 4'b0001 << lane;
        wdata_rep = {4{req_wdata[7:0]}};
      end
      MEM_SIZE_H: begin
        size_eff   = MEM_SIZE_H;
        lane_eff   = {lane[1], 1'b0};
        be         = lane[1] ? 4'b1100 : 4'b0011;
        wdata_rep  = {2{req_wdata[15:0]}};
        misaligned = lane[0];
      end
      default: misaligned = (lane != 2'b00);
    endcase
  end

  assign err = out_of_range || ((CHECK_ALIGN != 0) && misaligned);

  assign rd_word  = mem[idx];
  assign rd_shift = rd_word >> {lane_eff, 3'b000};

  always_comb begin
    rdata_fmt = rd_word;
    if (size_eff == MEM_SIZE_B)
      rdata_fmt = {{24{req_sign & rd_shift[7]}}, rd_shift[7:0]};
    else if (size_eff == MEM_SIZE_H)
      rdata_fmt = {{16{req_sign & rd_shift[15]}}, rd_shift[15:0]};
    if (err || req_we)
      rdata_fmt = '0;
  end

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (LATENCY == 1) begin
            state_nxt = RESP;
          end else begin
            state_nxt = WAIT;
            cnt_nxt   = CNT_W'(LATENCY - 1);
          end
        end
      end
      WAIT: begin
        cnt_nxt = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1))
          state_nxt = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready)
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign accept = req_valid && req_ready;
  assign wr_en  = accept && req_we && !err && rst_n;

  // Response payload is formed at accept so it stays frozen through WAIT and RESP
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (accept) begin
        resp_rdata <= rdata_fmt;
        resp_err   <= err;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b])
          mem[idx][8*b +: 8] <= wdata_rep[8*b +: 8];
      end
    end
  end
endmodule
